datamem_resp: RTL and testbench

//  Memory-side responder for the CPU data-memory port: accepts load/store

---
 rtl/datamem_resp_if.sv | 27 ++
 rtl/datamem_resp.sv | 143 ++++++++++++++
 tb/tb_datamem_resp.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_resp_if.sv
// Data-memory request/response bundle between the CPU and its memory responder.
// The master drives requests and response acceptance; the slave answers.
interface datamem_resp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              dr;
    logic              dw;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, dr, dw, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, dr, dw, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/datamem_resp.sv
// Wait-state data memory: accepts one load/store, answers after WAIT_CYC
// cycles on a valid/ready response channel, holding the response until taken.
module datamem_resp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT_CYC   = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    datamem_resp_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LD =
        4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  dw_q;
    logic                  bad_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;

    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic                  req_bad;
    logic                  accept;
    logic                  take;
    logic                  enter_rsp;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [DATA_W-1:0]     cur_wdata;
    logic                  cur_dw;
    logic                  cur_bad;

    assign req_bad = (bus.dr == bus.dw)
                   | (|bus.req_addr[1:0])
                   | (|bus.req_addr[ADDR_W-1:DEPTH_LOG2+2]);

    assign accept    = bus.req_ready & bus.req_valid;
    assign take      = (state_q == S_RESP) & bus.rsp_ready;
    assign enter_rsp = (state_d == S_RESP) & (state_q != S_RESP);

    // With zero wait states RESP is entered on the accept edge itself,
    // so the commit must see the live request instead of the latched copy.
    always_comb begin
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_dw    = dw_q;
        cur_bad   = bad_q;
        if (state_q == S_IDLE) begin
            cur_idx   = bus.req_addr[DEPTH_LOG2+1:2];
            cur_wdata = bus.req_wdata;
            cur_dw    = bus.dw;
            cur_bad   = req_bad;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYC == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = reset_n & (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            wdata_q <= '0;
            dw_q    <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                idx_q   <= bus.req_addr[DEPTH_LOG2+1:2];
                wdata_q <= bus.req_wdata;
                dw_q    <= bus.dw;
                bad_q   <= req_bad;
            end
            if (enter_rsp) begin
                rdata_q <= (cur_bad | cur_dw) ? '0 : mem_q[cur_idx];
                err_q   <= cur_bad;
            end else if (take) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_rsp & cur_dw & ~cur_bad) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end
endmodule

// File: tb/tb_datamem_resp.sv
// Scoreboard bench for datamem_resp: a wait-state instance for the main
// traffic and a zero-wait instance for the single-cycle latency case.
module tb_datamem_resp;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    datamem_resp_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    datamem_resp_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

    datamem_resp #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYC(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    datamem_resp #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYC(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model[int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rsp = 0;
    int          n_iss = 0;
    int          rmode = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per completed response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                chk("rsp_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                end
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                         input logic r, input logic w,
                         input logic [31:0] er, input logic ee,
                         input bit push);
        int k;
        bit ok;
        exp_t e;
        k  = 0;
        ok = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.dr        = r;
        bus.dw        = w;
        bus.req_valid = 1'b1;
        while (!ok && k < 50) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            k++;
        end
        #1;
        bus.req_valid = 1'b0;
        chk("req_accepted", 32'(ok), 32'd1);
        if (ok && push) begin
            e.rdata = er;
            e.err   = ee;
            q.push_back(e);
            n_iss++;
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        model[int'(a)] = d;
        issue(a, d, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic ld(input logic [31:0] a);
        issue(a, 32'h0, 1'b1, 1'b0, model[int'(a)], 1'b0, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] addrs[20];
        int k;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.dr        = 1'b0;
        bus.dw        = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.dr        = 1'b0;
        bus0.dw        = 1'b0;
        bus0.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Store interrupted by reset while waiting
        st(32'h20, 32'h1111_1111);
        drain();
        issue(32'h20, 32'h2222_2222, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("postrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        ld(32'h20);
        drain();

        // Latency with two wait states: driven after edge N, valid after N+3
        st(32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lat_n1_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n3_valid", {31'b0, bus.rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        ld(32'h10);
        drain();

        // Backpressure: response held, new request refused
        st(32'h30, 32'h3030_3030);
        st(32'h0, 32'hA5A5_A5A5);
        drain();
        rmode = 2;
        @(posedge clk);
        #1;
        ld(32'h10);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp_rsp_seen", {31'b0, bus.rsp_valid}, 32'd1);
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'hBADB_AD00;
        bus.dr        = 1'b0;
        bus.dw        = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        rmode = 0;
        drain();
        ld(32'h30);
        drain();

        // Error requests leave memory untouched
        issue(32'h13, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        issue(32'h400, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        issue(32'h30, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
        issue(32'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        issue(32'h11, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        ld(32'h10);
        ld(32'h0);
        ld(32'h30);
        drain();

        // Zero wait states: driven after edge N, valid after N+1
        bus0.req_addr  = 32'h8;
        bus0.req_wdata = 32'h0BAD_CAFE;
        bus0.dr        = 1'b0;
        bus0.dw        = 1'b1;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        chk("z_req_ready", {31'b0, bus0.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("z_st_valid", {31'b0, bus0.rsp_valid}, 32'd1);
        chk("z_st_err", {31'b0, bus0.rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        bus0.dr        = 1'b1;
        bus0.dw        = 1'b0;
        bus0.req_valid = 1'b1;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("z_ld_valid", {31'b0, bus0.rsp_valid}, 32'd1);
        chk("z_ld_rdata", bus0.rsp_rdata, 32'h0BAD_CAFE);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("z_idle_valid", {31'b0, bus0.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Stream of stores then loads with random response stalls
        rmode = 1;
        for (int i = 0; i < 20; i++) begin
            addrs[i] = 32'($urandom_range(0, 255)) << 2;
            st(addrs[i], $urandom);
        end
        for (int i = 0; i < 20; i++) begin
            ld(addrs[i]);
        end
        drain();
        rmode = 0;
        repeat (3) @(posedge clk);
        chk("rsp_count", 32'(n_rsp), 32'(n_iss));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
